// File: rtl/pong_pkg.sv
// ============================================================================
// Module   : pong_pkg
// Brief    : Shared state encoding, winner codes and screen constants for Pong.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pong_pkg;

    typedef enum logic [1:0] {
        ST_SERVE_WAIT = 2'd0,
        ST_RALLY      = 2'd1,
        ST_POINT      = 2'd2,
        ST_GAME_OVER  = 2'd3
    } state_t;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

    localparam logic [9:0] CENTRE_X = 10'd320;
    localparam logic [8:0] CENTRE_Y = 9'd240;

    localparam logic [3:0] MAX_SPEED = 4'd7;

endpackage

`default_nettype wire

// File: rtl/pong_frame_timer.sv
// ============================================================================
// Module   : pong_frame_timer
// Brief    : frame_tick-driven down-counter; expires on the tick seen at zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pong_frame_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Loading N-1 therefore yields an expiry on exactly the Nth tick.
    assign expire_o = tick_i && (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/pong_match_ctrl.sv
// ============================================================================
// Module   : pong_match_ctrl
// Brief    : Pong match sequencer (serve/rally/point/game-over, scores, ball gating).
//            Optional feature macro: PONG_SPEEDUP_EN (paddle-hit ball speed-up).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 5,
    parameter int POINT_FRAMES = 60,
    parameter int BLINK_FRAMES = 30,
    parameter int BASE_SPEED   = 3
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       frame_tick,
    input  logic       serve_btn,
    input  logic       new_game,
    input  logic       miss_left,
    input  logic       miss_right,
    input  logic       paddle_hit,
    output logic       ball_reset,
    output logic       ball_enable,
    output logic       serve_dir,
    output logic [3:0] ball_speed,
    output logic [2:0] score1,
    output logic [2:0] score2,
    output logic       numbers_active,
    output logic [1:0] winner,
    output logic       blink
);

    localparam int MAX_FRAMES = (POINT_FRAMES > BLINK_FRAMES) ? POINT_FRAMES : BLINK_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    localparam logic [CNT_W-1:0] POINT_LOAD = CNT_W'(POINT_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [2:0]       WIN3       = 3'(WIN_SCORE);
    localparam logic [3:0]       BASE4      = 4'(BASE_SPEED);

    state_t           state_q, state_d;
    logic             serve_prev_q;
    logic [2:0]       score1_q, score1_d, score2_q, score2_d;
    logic             dir_q, dir_d;
    logic [3:0]       speed_q, speed_d;
    logic [1:0]       winner_q, winner_d;
    logic             blink_q, blink_d;
    logic             ball_reset_q, ball_enable_q, numbers_q;
    logic             serve_rise;
    logic             tmr_load, tmr_expire;
    logic [CNT_W-1:0] tmr_val;

`ifdef PONG_SPEEDUP_EN
    logic [1:0] hit_cnt_q, hit_cnt_d;
`else
    logic unused_paddle_hit;
    assign unused_paddle_hit = paddle_hit;
`endif

    assign serve_rise = serve_btn & ~serve_prev_q;

    pong_frame_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (CLOCK_50),
        .rst_n      (RESET_N),
        .tick_i     (frame_tick),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q       <= ST_SERVE_WAIT;
            serve_prev_q  <= 1'b0;
            score1_q      <= '0;
            score2_q      <= '0;
            dir_q         <= 1'b0;
            speed_q       <= BASE4;
            winner_q      <= WINNER_NONE;
            blink_q       <= 1'b0;
            ball_reset_q  <= 1'b1;
            ball_enable_q <= 1'b0;
            numbers_q     <= 1'b1;
`ifdef PONG_SPEEDUP_EN
            hit_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            serve_prev_q  <= serve_btn;
            score1_q      <= score1_d;
            score2_q      <= score2_d;
            dir_q         <= dir_d;
            speed_q       <= speed_d;
            winner_q      <= winner_d;
            blink_q       <= blink_d;
            ball_reset_q  <= (state_d != ST_RALLY);
            ball_enable_q <= (state_d == ST_RALLY);
            numbers_q     <= (state_d != ST_RALLY);
`ifdef PONG_SPEEDUP_EN
            hit_cnt_q     <= hit_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        score1_d  = score1_q;
        score2_d  = score2_q;
        dir_d     = dir_q;
        speed_d   = speed_q;
        winner_d  = winner_q;
        blink_d   = blink_q;
        tmr_load  = 1'b0;
        tmr_val   = POINT_LOAD;
`ifdef PONG_SPEEDUP_EN
        hit_cnt_d = hit_cnt_q;
`endif
        if (new_game) begin
            state_d   = ST_SERVE_WAIT;
            score1_d  = '0;
            score2_d  = '0;
            winner_d  = WINNER_NONE;
            blink_d   = 1'b0;
            speed_d   = BASE4;
`ifdef PONG_SPEEDUP_EN
            hit_cnt_d = '0;
`endif
        end else begin
            case (state_q)
                ST_SERVE_WAIT: begin
                    if (serve_rise) begin
                        state_d   = ST_RALLY;
                        speed_d   = BASE4;
`ifdef PONG_SPEEDUP_EN
                        hit_cnt_d = '0;
`endif
                    end
                end
                ST_RALLY: begin
                    // miss_left is checked first so a simultaneous miss_right is dropped.
                    if (miss_left) begin
                        if (score2_q < WIN3) score2_d = score2_q + 3'd1;
                        dir_d    = 1'b0;
                        state_d  = ST_POINT;
                        tmr_load = 1'b1;
                        tmr_val  = POINT_LOAD;
                    end else if (miss_right) begin
                        if (score1_q < WIN3) score1_d = score1_q + 3'd1;
                        dir_d    = 1'b1;
                        state_d  = ST_POINT;
                        tmr_load = 1'b1;
                        tmr_val  = POINT_LOAD;
                    end
`ifdef PONG_SPEEDUP_EN
                    else if (paddle_hit) begin
                        hit_cnt_d = hit_cnt_q + 2'd1;
                        if ((hit_cnt_q == 2'd3) && (speed_q < MAX_SPEED))
                            speed_d = speed_q + 4'd1;
                    end
`endif
                end
                ST_POINT: begin
                    if (tmr_expire) begin
                        if ((score1_q == WIN3) || (score2_q == WIN3)) begin
                            state_d  = ST_GAME_OVER;
                            winner_d = (score1_q == WIN3) ? WINNER_P1 : WINNER_P2;
                            blink_d  = 1'b0;
                            tmr_load = 1'b1;
                            tmr_val  = BLINK_LOAD;
                        end else begin
                            state_d = ST_SERVE_WAIT;
                        end
                    end
                end
                default: begin
                    if (tmr_expire) begin
                        blink_d  = ~blink_q;
                        tmr_load = 1'b1;
                        tmr_val  = BLINK_LOAD;
                    end
                end
            endcase
        end
    end

    assign ball_reset     = ball_reset_q;
    assign ball_enable    = ball_enable_q;
    assign serve_dir      = dir_q;
    assign ball_speed     = speed_q;
    assign score1         = score1_q;
    assign score2         = score2_q;
    assign numbers_active = numbers_q;
    assign winner         = winner_q;
    assign blink          = blink_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_match_ctrl.sv
// ============================================================================
// Module   : tb_pong_match_ctrl
// Brief    : Directed self-checking bench for pong_match_ctrl (honours PONG_SPEEDUP_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pong_match_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N = 1'b0;
    logic       frame_tick = 1'b0, serve_btn = 1'b0, new_game = 1'b0;
    logic       miss_left = 1'b0, miss_right = 1'b0, paddle_hit = 1'b0;
    logic       ball_reset, ball_enable, serve_dir, numbers_active, blink;
    logic [3:0] ball_speed;
    logic [2:0] score1, score2;
    logic [1:0] winner;

    int checks = 0;
    int failures = 0;

`ifdef PONG_SPEEDUP_EN
    localparam logic [7:0] SPEED_AFTER_8 = 8'd5;
`else
    localparam logic [7:0] SPEED_AFTER_8 = 8'd3;
`endif

    pong_match_ctrl dut (
        .CLOCK_50       (CLOCK_50),
        .RESET_N        (RESET_N),
        .frame_tick     (frame_tick),
        .serve_btn      (serve_btn),
        .new_game       (new_game),
        .miss_left      (miss_left),
        .miss_right     (miss_right),
        .paddle_hit     (paddle_hit),
        .ball_reset     (ball_reset),
        .ball_enable    (ball_enable),
        .serve_dir      (serve_dir),
        .ball_speed     (ball_speed),
        .score1         (score1),
        .score2         (score2),
        .numbers_active (numbers_active),
        .winner         (winner),
        .blink          (blink)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
        end
    endtask

    task automatic serve();
        serve_btn = 1'b1;
        step(1);
        serve_btn = 1'b0;
        step(1);
    endtask

    task automatic miss(input logic l, input logic r);
        miss_left  = l;
        miss_right = r;
        step(1);
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    initial begin
        step(2);
        check("rst_ball_reset", 8'(ball_reset), 8'd1);
        check("rst_ball_enable", 8'(ball_enable), 8'd0);
        check("rst_serve_dir", 8'(serve_dir), 8'd0);
        check("rst_speed", 8'(ball_speed), 8'd3);
        check("rst_scores", 8'({score1, score2}), 8'd0);
        check("rst_numbers", 8'(numbers_active), 8'd1);
        check("rst_winner", 8'(winner), 8'd0);
        check("rst_blink", 8'(blink), 8'd0);

        RESET_N = 1'b1;
        step(1);
        serve_btn = 1'b1;
        step(1);
        check("serve_enable", 8'(ball_enable), 8'd1);
        check("serve_reset", 8'(ball_reset), 8'd0);
        check("serve_numbers", 8'(numbers_active), 8'd0);
        check("serve_speed", 8'(ball_speed), 8'd3);
        serve_btn = 1'b0;
        step(1);

        miss(1'b0, 1'b1);
        check("mr_score1", 8'(score1), 8'd1);
        check("mr_dir", 8'(serve_dir), 8'd1);
        check("mr_reset", 8'(ball_reset), 8'd1);
        check("mr_enable", 8'(ball_enable), 8'd0);
        ticks(59);
        serve();
        check("point59_serve_ignored", 8'(ball_enable), 8'd0);
        ticks(1);
        check("point_done_reset", 8'(ball_reset), 8'd1);
        serve();
        check("reserve_enable", 8'(ball_enable), 8'd1);

        miss(1'b1, 1'b1);
        check("both_score2", 8'(score2), 8'd1);
        check("both_score1", 8'(score1), 8'd1);
        check("both_dir", 8'(serve_dir), 8'd0);
        ticks(60);
        serve();

        for (int i = 0; i < 8; i++) begin
            paddle_hit = 1'b1;
            step(1);
            paddle_hit = 1'b0;
        end
        check("hits8_speed", 8'(ball_speed), SPEED_AFTER_8);
        miss(1'b1, 1'b0);
        ticks(60);
        serve();
        check("reserve_speed", 8'(ball_speed), 8'd3);
        for (int i = 0; i < 2; i++) begin
            miss(1'b1, 1'b0);
            ticks(60);
            serve();
        end
        check("score2_four", 8'(score2), 8'd4);
        miss(1'b1, 1'b0);
        check("score2_five", 8'(score2), 8'd5);
        check("winner_in_point", 8'(winner), 8'd0);
        ticks(60);
        check("winner_p2", 8'(winner), 8'd2);
        check("go_blink0", 8'(blink), 8'd0);
        miss(1'b1, 1'b0);
        check("go_score2_sat", 8'(score2), 8'd5);
        check("go_score1", 8'(score1), 8'd1);
        serve();
        check("go_serve_ignored", 8'(ball_enable), 8'd0);
        ticks(29);
        check("blink_29", 8'(blink), 8'd0);
        ticks(1);
        check("blink_30", 8'(blink), 8'd1);
        ticks(30);
        check("blink_60", 8'(blink), 8'd0);

        new_game = 1'b1;
        step(1);
        new_game = 1'b0;
        check("ng_scores", 8'({score1, score2}), 8'd0);
        check("ng_winner", 8'(winner), 8'd0);
        serve();
        check("ng_serve", 8'(ball_enable), 8'd1);

        new_game  = 1'b1;
        miss_left = 1'b1;
        step(1);
        new_game  = 1'b0;
        miss_left = 1'b0;
        check("ngmiss_score2", 8'(score2), 8'd0);
        check("ngmiss_reset", 8'(ball_reset), 8'd1);
        serve();
        check("ngmiss_wait_state", 8'(ball_enable), 8'd1);

        miss(1'b0, 1'b1);
        ticks(60);
        serve();
        check("pre_rst_score1", 8'(score1), 8'd1);
        RESET_N = 1'b0;
        step(1);
        RESET_N = 1'b1;
        check("midrst_enable", 8'(ball_enable), 8'd0);
        check("midrst_reset", 8'(ball_reset), 8'd1);
        check("midrst_score1", 8'(score1), 8'd0);
        check("midrst_dir", 8'(serve_dir), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
